// File: rtl/crossy_robbers_soc_key_pio_if.sv
// Avalon-MM slave bus for the key PIO: word address, select, write strobe and data.
interface crossy_robbers_soc_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/crossy_robbers_soc_key_pio.sv
// Debounced key/status input PIO with rising-edge capture and a level interrupt.
// Each pin is synchronized, then debounced: a new level is accepted only after
// DEBOUNCE_CYCLES consecutive samples that differ from the accepted level.
module crossy_robbers_soc_key_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  crossy_robbers_soc_key_pio_if.slave   bus,
  input  logic [WIDTH-1:0]              in_port,
  output logic                          irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] ec_clr;
  logic [CW-1:0]    cnt [WIDTH];
  logic             wr;

  // Only the low WIDTH data bits carry register content.
  logic unused_wd;
  assign unused_wd = ^bus.writedata;

  assign wr   = bus.chipselect & ~bus.write_n;
  assign rise = stable & ~stable_d;

  // Synchronize pins, then debounce each bit against its accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Write-1-to-clear mask for the edge-capture register.
  always_comb begin
    ec_clr = '0;
    if (wr && bus.address == 2'd3) ec_clr = bus.writedata[WIDTH-1:0];
  end

  // Mask register and edge capture; a new rising edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr && bus.address == 2'd2) irqmask <= bus.writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~ec_clr) | rise;
    end
  end

  // Zero-wait-state read mux; unused upper bits read as zero.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata[WIDTH-1:0] = stable;
      2'd2:    bus.readdata[WIDTH-1:0] = irqmask;
      2'd3:    bus.readdata[WIDTH-1:0] = edgecapture;
      default: bus.readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_crossy_robbers_soc_key_pio.sv
// Directed bench for the key PIO with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_crossy_robbers_soc_key_pio;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_port;
  logic       irq;
  int         total = 0;
  int         bad   = 0;

  crossy_robbers_soc_key_pio_if bus();

  crossy_robbers_soc_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pins;
    logic        wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    int          cycles;
    logic [31:0] e0;
    logic [31:0] e2;
    logic [31:0] e3;
    logic        eirq;
  } vec_t;

  vec_t vt [15];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(name, bus.readdata, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    step(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    // pins, wr, waddr, wdata, cycles, addr0, addr2, addr3, irq
    vt[0]  = '{4'b0001, 1'b1, 2'd3, 32'h1,        1, 32'h1, 32'h0, 32'h0, 1'b0};
    vt[1]  = '{4'b0001, 1'b1, 2'd0, 32'hF,        1, 32'h1, 32'h0, 32'h0, 1'b0};
    vt[2]  = '{4'b0001, 1'b1, 2'd1, 32'hF,        1, 32'h1, 32'h0, 32'h0, 1'b0};
    vt[3]  = '{4'b0011, 1'b0, 2'd0, 32'h0,        3, 32'h1, 32'h0, 32'h0, 1'b0};
    vt[4]  = '{4'b0001, 1'b0, 2'd0, 32'h0,        8, 32'h1, 32'h0, 32'h0, 1'b0};
    vt[5]  = '{4'b0001, 1'b1, 2'd2, 32'h2,        1, 32'h1, 32'h2, 32'h0, 1'b0};
    vt[6]  = '{4'b0011, 1'b0, 2'd0, 32'h0,        6, 32'h3, 32'h2, 32'h0, 1'b0};
    vt[7]  = '{4'b0011, 1'b0, 2'd0, 32'h0,        1, 32'h3, 32'h2, 32'h2, 1'b1};
    vt[8]  = '{4'b0011, 1'b1, 2'd3, 32'h2,        1, 32'h3, 32'h2, 32'h0, 1'b0};
    vt[9]  = '{4'b0001, 1'b0, 2'd0, 32'h0,        8, 32'h1, 32'h2, 32'h0, 1'b0};
    vt[10] = '{4'b0001, 1'b1, 2'd2, 32'h0,        1, 32'h1, 32'h0, 32'h0, 1'b0};
    vt[11] = '{4'b0101, 1'b0, 2'd0, 32'h0,        7, 32'h5, 32'h0, 32'h4, 1'b0};
    vt[12] = '{4'b0101, 1'b1, 2'd2, 32'h4,        1, 32'h5, 32'h4, 32'h4, 1'b1};
    vt[13] = '{4'b0101, 1'b1, 2'd3, 32'h4,        1, 32'h5, 32'h4, 32'h0, 1'b0};
    vt[14] = '{4'b0101, 1'b1, 2'd2, 32'hFFFFFFFF, 1, 32'h5, 32'hF, 32'h0, 1'b0};

    reset          = 1'b1;
    in_port        = 4'b0000;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    step(2);

    for (int a = 0; a < 4; a++) chk_rd($sformatf("reset_rd%0d", a), 2'(a), 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);

    // Debounce latency from a clean level change right at reset release.
    reset   = 1'b0;
    in_port = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk_rd($sformatf("lat_stable_e%0d", k), 2'd0, (k >= 6) ? 32'h1 : 32'h0);
      chk_rd($sformatf("lat_edge_e%0d", k), 2'd3, (k >= 7) ? 32'h1 : 32'h0);
    end

    // Table of register writes, glitches, presses and releases.
    for (int i = 0; i < 15; i++) begin
      in_port        = vt[i].pins;
      bus.chipselect = vt[i].wr;
      bus.write_n    = ~vt[i].wr;
      bus.address    = vt[i].waddr;
      bus.writedata  = vt[i].wdata;
      step(1);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      if (vt[i].cycles > 1) step(vt[i].cycles - 1);
      chk_rd($sformatf("vec%0d_rd0", i), 2'd0, vt[i].e0);
      chk_rd($sformatf("vec%0d_rd1", i), 2'd1, 32'h0);
      chk_rd($sformatf("vec%0d_rd2", i), 2'd2, vt[i].e2);
      chk_rd($sformatf("vec%0d_rd3", i), 2'd3, vt[i].e3);
      chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vt[i].eirq});
    end

    // Clear-all write lands on the same edge that captures bit0: set wins.
    in_port = 4'b0100;
    step(10);
    chk_rd("coll_pre_stable", 2'd0, 32'h4);
    in_port = 4'b0101;
    step(6);
    chk_rd("coll_pre_edge", 2'd3, 32'h0);
    bus_write(2'd3, 32'hF);
    chk_rd("coll_edge", 2'd3, 32'h1);
    chk("coll_irq", {31'h0, irq}, 32'h1);

    // Fill edgecapture, leave counters mid-count, then reset during a write.
    in_port = 4'b0000;
    step(10);
    bus_write(2'd3, 32'hF);
    in_port = 4'b1111;
    step(7);
    chk_rd("mid_ec_full", 2'd3, 32'hF);
    chk("mid_irq_pre", {31'h0, irq}, 32'h1);
    in_port = 4'b0101;
    step(4);
    in_port        = 4'b1111;
    reset          = 1'b1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = 2'd2;
    bus.writedata  = 32'hF;
    step(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    for (int a = 0; a < 4; a++) chk_rd($sformatf("mid_rst_rd%0d", a), 2'(a), 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    step(6);
    chk_rd("recap_stable_e6", 2'd0, 32'hF);
    chk_rd("recap_edge_e6", 2'd3, 32'h0);
    step(1);
    chk_rd("recap_edge_e7", 2'd3, 32'hF);
    chk("recap_irq", {31'h0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
